// File: rtl/fpnew_pkg.sv
// Shared FPnew types and helpers used by the lane sequencer: FP formats,
// rounding modes, operations, status flags and the sequencer state encoding.
package fpnew_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100,
    ROD = 3'b101,
    DYN = 3'b111
  } roundmode_e;

  typedef enum logic [3:0] {
    FMADD    = 4'd0,
    FNMSUB   = 4'd1,
    ADD      = 4'd2,
    MUL      = 4'd3,
    DIV      = 4'd4,
    SQRT     = 4'd5,
    SGNJ     = 4'd6,
    MINMAX   = 4'd7,
    CMP      = 4'd8,
    CLASSIFY = 4'd9,
    F2F      = 4'd10,
    F2I      = 4'd11,
    I2F      = 4'd12,
    CPKAB    = 4'd13,
    CPKCD    = 4'd14
  } operation_e;

  typedef struct packed {
    logic NV;  // invalid
    logic DZ;  // divide by zero
    logic OF;  // overflow
    logic UF;  // underflow
    logic NX;  // inexact
  } status_t;

  // Sequencer control states: waiting for an op, issuing/collecting lanes,
  // holding the reassembled result for the consumer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lane_seq_state_e;

  // Bit width of one element of the given format.
  function automatic int unsigned fp_width(fp_format_e fmt);
    case (fmt)
      FP32:          return 32'd32;
      FP64:          return 32'd64;
      FP16, FP16ALT: return 32'd16;
      FP8:           return 32'd8;
      default:       return 32'd32;
    endcase
  endfunction

  // Number of elements of the given format packed into a datapath of 'width'.
  function automatic int unsigned num_lanes(int unsigned width, fp_format_e fmt, logic vec);
    if (vec && (width >= fp_width(fmt))) begin
      return width / fp_width(fmt);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/fpnew_lane_sequencer.sv
// Runs a vectorial FP operation through a single FP lane unit: the lanes of
// the captured operands are issued one per handshake, the in-order results are
// gathered into a buffer and returned as one full-width result with OR-ed
// status flags and extension-bit fill above the active lanes.
module fpnew_lane_sequencer
  import fpnew_pkg::*;
#(
  parameter fp_format_e  FpFormat      = fp_format_e'(0),
  parameter int unsigned Width         = 64,
  parameter logic        EnableVectors = 1'b1,
  parameter int unsigned NumOperands   = 3,
  parameter type         TagType       = logic,
  localparam int unsigned FP_WIDTH  = fp_width(FpFormat),
  localparam int unsigned NUM_LANES = num_lanes(Width, FpFormat, EnableVectors),
  localparam int unsigned CNT_W     = $clog2(NUM_LANES + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumOperands-1:0][Width-1:0]     operands_i,
  input  logic [NumOperands-1:0]                is_boxed_i,
  input  roundmode_e                            rnd_mode_i,
  input  operation_e                            op_i,
  input  logic                                  op_mod_i,
  input  logic                                  vectorial_op_i,
  input  TagType                                tag_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic                                  flush_i,
  output logic [NumOperands-1:0][FP_WIDTH-1:0]  lane_operands_o,
  output logic [NumOperands-1:0]                lane_is_boxed_o,
  output roundmode_e                            lane_rnd_mode_o,
  output operation_e                            lane_op_o,
  output logic                                  lane_op_mod_o,
  output logic                                  lane_in_valid_o,
  input  logic                                  lane_in_ready_i,
  output logic                                  lane_flush_o,
  input  logic [FP_WIDTH-1:0]                   lane_result_i,
  input  status_t                               lane_status_i,
  input  logic                                  lane_ext_bit_i,
  input  logic                                  lane_out_valid_i,
  output logic                                  lane_out_ready_o,
  output logic [Width-1:0]                      result_o,
  output status_t                               status_o,
  output logic                                  extension_bit_o,
  output TagType                                tag_o,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic                                  busy_o
);

  lane_seq_state_e                     state;
  lane_seq_state_e                     state_next;
  logic [CNT_W-1:0]                    issue_cnt;
  logic [CNT_W-1:0]                    coll_cnt;
  logic [CNT_W-1:0]                    lane_count;
  logic [NumOperands-1:0][Width-1:0]   reg_operands;
  logic [NumOperands-1:0]              reg_is_boxed;
  roundmode_e                          reg_rnd_mode;
  operation_e                          reg_op;
  logic                                reg_op_mod;
  TagType                              reg_tag;
  logic [NUM_LANES-1:0][FP_WIDTH-1:0]  slots;
  status_t                             status_acc;
  logic                                ext;

  logic accept;
  logic issue_fire;
  logic coll_fire;
  logic last_coll;

  assign accept     = in_valid_i & in_ready_o;
  assign issue_fire = lane_in_valid_o & lane_in_ready_i;
  assign coll_fire  = lane_out_valid_i & lane_out_ready_o;
  assign last_coll  = coll_fire & (coll_cnt == (lane_count - CNT_W'(1)));

  // Handshake outputs per state and next-state selection; flush dominates.
  always_comb begin
    state_next       = state;
    in_ready_o       = 1'b0;
    lane_in_valid_o  = 1'b0;
    lane_out_ready_o = 1'b0;
    out_valid_o      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = ~flush_i;
      end
      RUN: begin
        lane_in_valid_o  = (issue_cnt < lane_count);
        lane_out_ready_o = ~flush_i;
      end
      DONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i & ~flush_i;
      end
      default: begin
        in_ready_o = 1'b0;
      end
    endcase

    if (flush_i) begin
      state_next = IDLE;
    end else if (accept) begin
      state_next = RUN;
    end else if (last_coll) begin
      state_next = DONE;
    end else if ((state == DONE) && out_ready_i) begin
      state_next = IDLE;
    end else begin
      state_next = state;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operation capture, issue/collect counters and the lane result buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_operands <= '0;
      reg_is_boxed <= '0;
      reg_rnd_mode <= RNE;
      reg_op       <= FMADD;
      reg_op_mod   <= 1'b0;
      reg_tag      <= '0;
      lane_count   <= '0;
      issue_cnt    <= '0;
      coll_cnt     <= '0;
      slots        <= '0;
      status_acc   <= '0;
      ext          <= 1'b0;
    end else if (flush_i) begin
      issue_cnt <= '0;
      coll_cnt  <= '0;
    end else if (accept) begin
      reg_operands <= operands_i;
      reg_is_boxed <= is_boxed_i;
      reg_rnd_mode <= rnd_mode_i;
      reg_op       <= op_i;
      reg_op_mod   <= op_mod_i;
      reg_tag      <= tag_i;
      lane_count   <= (vectorial_op_i & EnableVectors) ? CNT_W'(NUM_LANES) : CNT_W'(1);
      issue_cnt    <= '0;
      coll_cnt     <= '0;
      status_acc   <= '0;
    end else begin
      // Valid only asserts below lane_count, so the issue count saturates there.
      if (issue_fire) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      // Lane results return in issue order, so coll_cnt names the slot.
      if (coll_fire) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (coll_cnt == CNT_W'(l)) begin
            slots[l] <= lane_result_i;
          end
        end
        status_acc <= status_t'(status_acc | lane_status_i);
        if (coll_cnt == '0) begin
          ext <= lane_ext_bit_i;
        end
        coll_cnt <= coll_cnt + CNT_W'(1);
      end
    end
  end

  // Slice of every operand belonging to the lane currently being issued.
  always_comb begin
    lane_operands_o = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int j = 0; j < NumOperands; j++) begin
        lane_operands_o[j] = lane_operands_o[j]
                           | ({FP_WIDTH{issue_cnt == CNT_W'(l)}}
                              & reg_operands[j][l*FP_WIDTH +: FP_WIDTH]);
      end
    end
  end

  // Reassemble: active lanes from the buffer, everything above filled with ext.
  always_comb begin
    result_o = {Width{ext}};
    for (int l = 0; l < NUM_LANES; l++) begin
      result_o[l*FP_WIDTH +: FP_WIDTH] = (CNT_W'(l) < lane_count) ? slots[l] : {FP_WIDTH{ext}};
    end
  end

  assign lane_is_boxed_o = reg_is_boxed;
  assign lane_rnd_mode_o = reg_rnd_mode;
  assign lane_op_o       = reg_op;
  assign lane_op_mod_o   = reg_op_mod;
  assign lane_flush_o    = flush_i;
  assign status_o        = status_acc;
  assign extension_bit_o = ext;
  assign tag_o           = reg_tag;
  assign busy_o          = (state != IDLE);

endmodule

// File: doc/fpnew_lane_sequencer.md
Name: fpnew_lane_sequencer

Overview:
- Time-multiplexes one single-lane FP operation unit (fma/noncomp-style lane, valid/ready both sides) across all lanes of a vectorial operation.
- Accepts one full-width operation upstream and issues its lanes to the unit one per handshake.
- Collects the lane results in order and returns one reassembled full-width result, with OR-collapsed status and the same NaN-box/sign-extend rules as a full vector slice.
- Lets area-constrained configs run vectorial ops with a single lane instance.

Parameters:
- FpFormat, fpnew_pkg::fp_format_e'(0), lane format; FP_WIDTH = fpnew_pkg::fp_width(FpFormat).
- Width, 64, upstream datapath width.
- EnableVectors, 1'b1, when 0 every op is treated as scalar.
- NumOperands, 3, operand count forwarded to the lane.
- TagType, logic, upstream tag type; held internally, never sent to the lane.
- NUM_LANES (localparam), fpnew_pkg::num_lanes(Width, FpFormat, EnableVectors).
- CNT_W (localparam), $clog2(NUM_LANES+1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- operands_i  in  NumOperands x Width  upstream operands
- is_boxed_i  in  NumOperands  NaN-box flags
- rnd_mode_i  in  fpnew_pkg::roundmode_e  rounding mode
- op_i  in  fpnew_pkg::operation_e  operation
- op_mod_i  in  1  operation modifier
- vectorial_op_i  in  1  vectorial request
- tag_i  in  TagType  tag
- in_valid_i / in_ready_o  in/out  1  upstream handshake
- flush_i  in  1  flush
- lane_operands_o  out  NumOperands x FP_WIDTH  operands for the current lane
- lane_is_boxed_o, lane_rnd_mode_o, lane_op_o, lane_op_mod_o  out  (as inputs)  registered op fields
- lane_in_valid_o / lane_in_ready_i  out/in  1  lane issue handshake
- lane_flush_o  out  1  equals flush_i
- lane_result_i  in  FP_WIDTH  lane result
- lane_status_i  in  fpnew_pkg::status_t  lane status
- lane_ext_bit_i  in  1  lane extension bit
- lane_out_valid_i / lane_out_ready_o  in/out  1  lane result handshake
- result_o  out  Width  assembled result
- status_o  out  fpnew_pkg::status_t  OR of lane statuses
- extension_bit_o  out  1  extension bit of lane 0
- tag_o  out  TagType  captured tag
- out_valid_o / out_ready_i  out/in  1  downstream handshake
- busy_o  out  1  operation in flight or result pending

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset (async, rst_ni=0) -> IDLE.
- At reset: counters 0, result buffer 0, status 0, in_ready_o=1, all other outputs 0.
- IDLE
  - in_ready_o=1.
  - On in_valid_i & in_ready_o: register operands, is_boxed, rnd_mode, op, op_mod, tag.
  - n = (vectorial_op_i & EnableVectors) ? NUM_LANES : 1.
  - issue_cnt=0, coll_cnt=0, status accumulator=0; go to RUN.
- RUN
  - lane_in_valid_o = (issue_cnt < n).
  - lane_operands_o[i] = reg_operands[i][issue_cnt*FP_WIDTH +: FP_WIDTH].
  - issue_cnt increments on each lane issue handshake.
  - lane_out_ready_o=1 in RUN only.
  - On lane_out_valid_i: slot[coll_cnt] <= lane_result_i, status |= lane_status_i; when coll_cnt==0 also capture ext <= lane_ext_bit_i; coll_cnt++.
  - Results are assumed in order: the lane unit is FIFO-ordered.
  - Issue and collect overlap, so pipelined lanes stay full.
  - When the collect completing coll_cnt==n-1 happens -> DONE next cycle.
- DONE
  - out_valid_o=1; tag_o and status_o are stable.
  - result_o: slots 0..n-1 hold the collected results; slots n..NUM_LANES-1 and bits above NUM_LANES*FP_WIDTH are filled with ext.
  - On out_ready_i -> IDLE.
  - in_ready_o = out_ready_i: a same-cycle accept loads the new op and goes straight to RUN (zero bubble).
- Latency, scalar op on a 1-cycle lane unit: accept (cycle 0), issue (cycle 1), collect (cycle 2), out_valid_o (cycle 3).
- lane_in_valid_o never asserts outside RUN; lane_out_valid_i outside RUN is ignored (lane_out_ready_o=0).
- Holding out_ready_i low in DONE holds all outputs stable indefinitely.
- flush_i (any state)
  - Next state IDLE; counters cleared; out_valid_o=0 next cycle.
  - In the flush cycle, in_ready_o=0 and lane_out_ready_o=0.
- busy_o = (state != IDLE).
- Counters never exceed n; issue_cnt saturates at n.

Decomposition:
- fpnew_pkg: add lane_seq_state_e {IDLE, RUN, DONE}.
- Reuse the existing fpnew_pkg::num_lanes, fp_width, status_t; no other shared constants.
- No sub-module needed: FSM, two counters and the result buffer live in this one module (~200 lines).

Test Plan:
1. Width=64, FP32, scalar; lane returns 0x3F800000, ext=1 -> result_o=0xFFFFFFFF_3F800000, out_valid_o at cycle 3 with a 1-cycle lane.
2. Vectorial FP32, operands {0x40000000, 0x3F800000}; lane echoes operand A -> lane_operands_o carries lane 0 then lane 1; result_o=0x40000000_3F800000.
3. Vectorial FP16 (4 lanes); lane_in_ready_i toggles 1,0,1,0 -> exactly 4 issues, slice order 0..3, result correctly reassembled.
4. Lane statuses NX on lane 1 and OF on lane 3 -> status_o has both NX and OF set, others 0.
5. flush_i after 2 of 4 issues -> IDLE next cycle, out_valid_o never asserts, busy_o=0; a new op afterwards completes normally.
6. DONE with out_ready_i=1 and in_valid_i=1 -> new op accepted same cycle, lane_in_valid_o high next cycle; with out_ready_i=0 for 5 cycles, result_o and tag_o stay stable.
